// File: rtl/logic_pkg.sv
// Shared widths and response-entry layout for the logic unit command server.
// The opcode encodings belong to logic_top.
package logic_pkg;

    localparam int LOGIC_WIDTH = 16;
    localparam int LOGIC_SEL_W = 3;
    localparam int LOGIC_TAG_W = 4;
    localparam int RSP_W       = LOGIC_WIDTH + LOGIC_SEL_W + LOGIC_TAG_W + 1;

    typedef struct packed {
        logic [LOGIC_WIDTH-1:0] result;
        logic [LOGIC_SEL_W-1:0] sel;
        logic [LOGIC_TAG_W-1:0] tag;
        logic                   zero;
    } rsp_entry_t;

endpackage

// File: rtl/logic_rsp_fifo.sv
// First-word-fall-through response FIFO with flush; read data reads zero when empty.
module logic_rsp_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_V = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;

    // The writer never pushes into a full FIFO unless it pops in the same cycle
    assign do_pop = pop && (count != {CW{1'b0}});
    assign empty  = (count == {CW{1'b0}});
    assign full   = (count == DEPTH_V);
    assign rdata  = empty ? {W{1'b0}} : mem[rd_ptr];

    // Storage array; contents are don't-care outside the valid window
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= {AW{1'b0}};
            rd_ptr <= {AW{1'b0}};
            count  <= {CW{1'b0}};
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!push && do_pop) begin
                count <= count - CW'(1);
            end else begin
                count <= count;
            end
        end
    end

endmodule

// File: rtl/logic_top.sv
// 16-bit bitwise logic unit: purely combinational, opcode selects the operation.
module logic_top #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] result
);

    // Opcode decode: AND, OR, XOR, NAND, NOR, XNOR, NOT in0, pass in0
    always_comb begin
        result = {WIDTH{1'b0}};
        case (sel)
            3'd0:    result = in0 & in1;
            3'd1:    result = in0 | in1;
            3'd2:    result = in0 ^ in1;
            3'd3:    result = ~(in0 & in1);
            3'd4:    result = ~(in0 | in1);
            3'd5:    result = ~(in0 ^ in1);
            3'd6:    result = ~in0;
            3'd7:    result = in0;
            default: result = in0;
        endcase
    end

endmodule

// File: rtl/logic_cmd_server.sv
// Valid/ready command server around logic_top: one register stage feeding a
// response FIFO, with tag/opcode echo, zero flag, flush and a response counter.
module logic_cmd_server
    import logic_pkg::*;
#(
    parameter int WIDTH      = LOGIC_WIDTH,
    parameter int SEL_W      = LOGIC_SEL_W,
    parameter int TAG_W      = LOGIC_TAG_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_in0,
    input  logic [WIDTH-1:0] cmd_in1,
    input  logic [SEL_W-1:0] cmd_sel,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [SEL_W-1:0] rsp_sel,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_zero,
    input  logic             flush,
    output logic             busy,
    output logic [15:0]      op_count
);

    localparam int ENTRY_W = WIDTH + SEL_W + TAG_W + 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);

    logic               s1_valid;
    logic [WIDTH-1:0]   s1_in0;
    logic [WIDTH-1:0]   s1_in1;
    logic [SEL_W-1:0]   s1_sel;
    logic [TAG_W-1:0]   s1_tag;
    logic [WIDTH-1:0]   s1_result;
    logic               s1_zero;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W:0]     occupancy;
    logic               cmd_hs;
    logic               rsp_hs;
    logic               push;
    logic               pop;

    logic_top #(.WIDTH(WIDTH)) u_logic (
        .in0    (s1_in0),
        .in1    (s1_in1),
        .sel    (s1_sel),
        .result (s1_result)
    );

    // Admission counts the entry still sitting in S1, so S1 never has to stall
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, s1_valid};
    assign cmd_ready = !rst && !flush && (occupancy < DEPTH_LIM);
    assign cmd_hs    = cmd_valid && cmd_ready;

    assign s1_zero    = (s1_result == {WIDTH{1'b0}});
    assign push_entry = {s1_result, s1_sel, s1_tag, s1_zero};
    assign push       = s1_valid && !flush && (!fifo_full || rsp_ready);
    assign pop        = rsp_ready && !flush;
    assign rsp_hs     = rsp_ready && !fifo_empty && !flush;

    logic_rsp_fifo #(.W(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rsp_valid  = !fifo_empty;
    assign rsp_result = head_entry[ENTRY_W-1 -: WIDTH];
    assign rsp_sel    = head_entry[TAG_W+1 +: SEL_W];
    assign rsp_tag    = head_entry[1 +: TAG_W];
    assign rsp_zero   = head_entry[0];
    assign busy       = s1_valid || !fifo_empty;

    // Stage S1: capture the accepted command
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_in0   <= {WIDTH{1'b0}};
            s1_in1   <= {WIDTH{1'b0}};
            s1_sel   <= {SEL_W{1'b0}};
            s1_tag   <= {TAG_W{1'b0}};
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (cmd_hs) begin
            s1_valid <= 1'b1;
            s1_in0   <= cmd_in0;
            s1_in1   <= cmd_in1;
            s1_sel   <= cmd_sel;
            s1_tag   <= cmd_tag;
        end else begin
            s1_valid <= 1'b0;
        end
    end

    // Completed-response counter; flush leaves it alone
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count <= 16'h0000;
        end else if (rsp_hs) begin
            op_count <= op_count + 16'h0001;
        end else begin
            op_count <= op_count;
        end
    end

endmodule

// File: tb/tb_logic_cmd_server.sv
// Directed self-checking bench for logic_cmd_server with a scoreboard fed by a golden logic_top.
module tb_logic_cmd_server;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_in0;
    logic [15:0] cmd_in1;
    logic [2:0]  cmd_sel;
    logic [3:0]  cmd_tag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [2:0]  rsp_sel;
    logic [3:0]  rsp_tag;
    logic        rsp_zero;
    logic        flush;
    logic        busy;
    logic [15:0] op_count;
    logic [15:0] gold_result;

    int          n_checks = 0;
    int          n_errors = 0;
    int          acc_cnt  = 0;
    logic [15:0] op_exp   = 16'h0000;
    logic [22:0] exp_q [$];

    logic_cmd_server dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_in0    (cmd_in0),
        .cmd_in1    (cmd_in1),
        .cmd_sel    (cmd_sel),
        .cmd_tag    (cmd_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_sel    (rsp_sel),
        .rsp_tag    (rsp_tag),
        .rsp_zero   (rsp_zero),
        .flush      (flush),
        .busy       (busy),
        .op_count   (op_count)
    );

    logic_top u_gold (
        .in0    (cmd_in0),
        .in1    (cmd_in1),
        .sel    (cmd_sel),
        .result (gold_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: sampled mid-cycle, reflects handshakes at the following rising edge
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            op_exp = 16'h0000;
        end else if (flush) begin
            exp_q.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    logic [22:0] e;
                    e = exp_q.pop_front();
                    check_eq("sb_result", {16'h0, rsp_result}, {16'h0, e[22:7]});
                    check_eq("sb_sel", {29'h0, rsp_sel}, {29'h0, e[6:4]});
                    check_eq("sb_tag", {28'h0, rsp_tag}, {28'h0, e[3:0]});
                    check_eq("sb_zero", {31'h0, rsp_zero}, {31'h0, (e[22:7] == 16'h0000)});
                end
                op_exp = op_exp + 16'h0001;
            end
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back({gold_result, cmd_sel, cmd_tag});
                acc_cnt++;
            end
        end
    end

    task automatic wait_idle(input int limit);
        int c;
        c = 0;
        while (busy && c < limit) begin
            step();
            c++;
        end
        check_eq("idle_timeout", {31'h0, busy}, 32'd0);
    endtask

    // Back-to-back issue of all 8 opcodes; responses checked 1/cycle against a hand table
    task automatic run_table(input string name, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] tbl [8]);
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cmd_valid = 1'b1;
            cmd_in0   = a;
            cmd_in1   = b;
            cmd_sel   = 3'(i);
            cmd_tag   = 4'(i);
            step();
            if (i > 0) begin
                check_eq({name, "_valid"}, {31'h0, rsp_valid}, 32'd1);
                check_eq({name, "_res"}, {16'h0, rsp_result}, {16'h0, tbl[i-1]});
                check_eq({name, "_zero"}, {31'h0, rsp_zero}, {31'h0, (tbl[i-1] == 16'h0000)});
            end
        end
        cmd_valid = 1'b0;
        step();
        check_eq({name, "_res7"}, {16'h0, rsp_result}, {16'h0, tbl[7]});
        check_eq({name, "_tag7"}, {28'h0, rsp_tag}, 32'd7);
        step();
        check_eq({name, "_drained"}, {31'h0, rsp_valid}, 32'd0);
    endtask

    // Stream 'total' commands; hold rsp_ready low for the first 'stall' cycles
    task automatic run_stream(input string name, input int total, input int stall, input logic [15:0] seed);
        int acc0;
        int k;
        int c;
        acc0 = acc_cnt;
        c = 0;
        k = 0;
        while ((k < total || busy) && c < 200) begin
            k = acc_cnt - acc0;
            rsp_ready = (c >= stall);
            cmd_valid = (k < total);
            cmd_in0   = seed + 16'(k);
            cmd_in1   = 16'hF0F0;
            cmd_sel   = 3'(k);
            cmd_tag   = 4'(k + 8);
            if (c == stall - 3 || c == stall) begin
                check_eq({name, "_head_tag"}, {28'h0, rsp_tag}, 32'd8);
                check_eq({name, "_head_res"}, {16'h0, rsp_result}, {16'h0, seed & 16'hF0F0});
            end
            if (c == stall) begin
                check_eq({name, "_acc_stall"}, acc_cnt - acc0, 32'd4);
                check_eq({name, "_rdy_full"}, {31'h0, cmd_ready}, 32'd0);
            end
            step();
            c++;
        end
        cmd_valid = 1'b0;
        check_eq({name, "_acc_total"}, acc_cnt - acc0, total);
        check_eq({name, "_op_count"}, {16'h0, op_count}, {16'h0, op_exp});
        check_eq({name, "_sb_empty"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        logic [15:0] sweep_tbl [8];
        logic [15:0] zero_tbl  [8];
        logic [15:0] op_base;
        int          acc0;
        int          c;

        sweep_tbl = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h5A5A, 16'hA5A5};
        zero_tbl  = '{16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000};

        rst = 1'b1; cmd_valid = 1'b0; cmd_in0 = 16'h0; cmd_in1 = 16'h0;
        cmd_sel = 3'd0; cmd_tag = 4'd0; rsp_ready = 1'b0; flush = 1'b0;
        repeat (3) step();
        check_eq("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        check_eq("rst_busy", {31'h0, busy}, 32'd0);
        check_eq("rst_cmd_ready", {31'h0, cmd_ready}, 32'd0);
        check_eq("rst_op_count", {16'h0, op_count}, 32'd0);
        check_eq("rst_rsp_result", {16'h0, rsp_result}, 32'd0);
        rst = 1'b0;
        step();

        // Single operation and latency
        check_eq("single_ready", {31'h0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_in0 = 16'h00FF; cmd_in1 = 16'h0F0F; cmd_sel = 3'b000; cmd_tag = 4'h3;
        rsp_ready = 1'b1;
        step();
        cmd_valid = 1'b0;
        check_eq("single_lat1", {31'h0, rsp_valid}, 32'd0);
        check_eq("single_busy", {31'h0, busy}, 32'd1);
        step();
        check_eq("single_valid", {31'h0, rsp_valid}, 32'd1);
        check_eq("single_result", {16'h0, rsp_result}, 32'h000F);
        check_eq("single_tag", {28'h0, rsp_tag}, 32'h3);
        step();
        check_eq("single_done", {31'h0, rsp_valid}, 32'd0);
        check_eq("single_opcnt", {16'h0, op_count}, 32'd1);

        run_table("sweep", 16'hA5A5, 16'h5A5A, sweep_tbl);
        check_eq("sweep_opcnt", {16'h0, op_count}, 32'd9);
        run_table("zero", 16'h0000, 16'h0000, zero_tbl);

        run_stream("bp", 6, 8, 16'h1234);
        run_stream("full", 12, 6, 16'h0F37);

        // Flush with 3 entries in flight
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1; cmd_in0 = 16'(i); cmd_in1 = 16'hFFFF; cmd_sel = 3'd1; cmd_tag = 4'(i);
            step();
        end
        op_base = op_exp;
        flush = 1'b1; cmd_tag = 4'hF;
        #1;
        check_eq("flush_ready", {31'h0, cmd_ready}, 32'd0);
        acc0 = acc_cnt;
        step();
        flush = 1'b0; cmd_valid = 1'b0;
        check_eq("flush_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        check_eq("flush_busy", {31'h0, busy}, 32'd0);
        check_eq("flush_opcnt", {16'h0, op_count}, {16'h0, op_base});
        step();
        check_eq("flush_no_accept", acc_cnt - acc0, 32'd0);
        check_eq("flush_still_empty", {31'h0, rsp_valid}, 32'd0);

        // Reset mid-stream
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1; cmd_in0 = 16'(i + 5); cmd_in1 = 16'h00F0; cmd_sel = 3'd2; cmd_tag = 4'(i);
            step();
        end
        rst = 1'b1; cmd_valid = 1'b0;
        step();
        check_eq("rst_mid_opcnt", {16'h0, op_count}, 32'd0);
        check_eq("rst_mid_valid", {31'h0, rsp_valid}, 32'd0);
        check_eq("rst_mid_busy", {31'h0, busy}, 32'd0);
        rst = 1'b0;
        step();

        // op_count wrap after 65536 responses
        acc0 = acc_cnt;
        rsp_ready = 1'b1;
        c = 0;
        while (op_count != 16'hFFFF && c < 70000) begin
            cmd_valid = ((acc_cnt - acc0) < 65536);
            cmd_in0 = 16'(c); cmd_in1 = ~16'(c); cmd_sel = 3'(c); cmd_tag = 4'(c);
            step();
            c++;
        end
        cmd_valid = 1'b0;
        check_eq("wrap_reached", {16'h0, op_count}, 32'h0000FFFF);
        check_eq("wrap_pending", {31'h0, rsp_valid}, 32'd1);
        step();
        check_eq("wrap_zero", {16'h0, op_count}, 32'd0);
        check_eq("wrap_accepts", acc_cnt - acc0, 32'd65536);
        wait_idle(10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
